// File: rtl/mem_bank_arbiter.sv
// Arbitrates one single-port RAM bank between the CPU port and a gfx read port.
// gfx has priority, but its run is bounded by MAX_GFX_RUN so a waiting CPU is never starved.
module mem_bank_arbiter #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 14,
  parameter int MAX_GFX_RUN  = 4
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] CPU_ADDR,
  input  logic [BITS-1:0]         CPU_DIN,
  input  logic                    CPU_WR,
  input  logic                    CPU_RD,
  output logic                    CPU_BUSY,
  output logic                    CPU_VALID,
  output logic [BITS-1:0]         CPU_DOUT,
  input  logic [ADDRESS_BITS-1:0] GFX_ADDR,
  input  logic                    GFX_RD,
  output logic                    GFX_BUSY,
  output logic                    GFX_VALID,
  output logic [BITS-1:0]         GFX_DOUT,
  output logic [ADDRESS_BITS-1:0] RAM_ADDR,
  output logic [BITS-1:0]         RAM_DIN,
  output logic                    RAM_WR,
  input  logic [BITS-1:0]         RAM_DOUT
);

  localparam int RUN_W = $clog2(MAX_GFX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_GFX_RUN);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_GFX  = 2'd2;

  logic [RUN_W-1:0] gfx_run_q, gfx_run_d;
  logic [1:0]       rd_tag_q, rd_tag_d;
  logic [BITS-1:0]  cpu_hold_q, cpu_hold_d;
  logic [BITS-1:0]  gfx_hold_q, gfx_hold_d;

  logic cpu_req;
  logic gfx_grant;
  logic cpu_grant;

  // Grants are forced off while reset is asserted, so no RAM access can start.
  always_comb begin
    cpu_req   = CPU_RD | CPU_WR;
    gfx_grant = RSTb & GFX_RD & (~cpu_req | (gfx_run_q < RUN_MAX));
    cpu_grant = RSTb & cpu_req & ~gfx_grant;
  end

  always_comb begin
    RAM_ADDR  = gfx_grant ? GFX_ADDR : CPU_ADDR;
    RAM_DIN   = CPU_DIN;
    RAM_WR    = cpu_grant & CPU_WR;
    CPU_BUSY  = cpu_req & ~cpu_grant;
    GFX_BUSY  = GFX_RD & ~gfx_grant;
    CPU_VALID = (rd_tag_q == TAG_CPU);
    GFX_VALID = (rd_tag_q == TAG_GFX);
    CPU_DOUT  = CPU_VALID ? RAM_DOUT : cpu_hold_q;
    GFX_DOUT  = GFX_VALID ? RAM_DOUT : gfx_hold_q;
  end

  always_comb begin
    gfx_run_d = gfx_run_q;
    if (gfx_grant && cpu_req) begin
      if (gfx_run_q != RUN_MAX) gfx_run_d = gfx_run_q + 1'b1;
    end else if (cpu_grant || !cpu_req) begin
      gfx_run_d = '0;
    end

    // A simultaneous read+write from the CPU is a write only, so it tags nothing.
    rd_tag_d = TAG_NONE;
    if (gfx_grant)                          rd_tag_d = TAG_GFX;
    else if (cpu_grant && CPU_RD && !CPU_WR) rd_tag_d = TAG_CPU;

    cpu_hold_d = CPU_VALID ? RAM_DOUT : cpu_hold_q;
    gfx_hold_d = GFX_VALID ? RAM_DOUT : gfx_hold_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      gfx_run_q  <= '0;
      rd_tag_q   <= TAG_NONE;
      cpu_hold_q <= '0;
      gfx_hold_q <= '0;
    end else begin
      gfx_run_q  <= gfx_run_d;
      rd_tag_q   <= rd_tag_d;
      cpu_hold_q <= cpu_hold_d;
      gfx_hold_q <= gfx_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Self-checking bench for mem_bank_arbiter: directed scenarios then random traffic,
// compared against a cycle-level behavioural model with its own memory image.
module tb_mem_bank_arbiter;

  localparam int BITS    = 16;
  localparam int AB      = 14;
  localparam int MAX_RUN = 4;
  localparam int DEPTH   = 1 << AB;

  logic          CLK = 1'b0;
  logic          rstb;
  logic [AB-1:0] cpu_addr, gfx_addr;
  logic [15:0]   cpu_din;
  logic          cpu_wr, cpu_rd, gfx_rd;

  logic          CPU_BUSY, CPU_VALID, GFX_BUSY, GFX_VALID, RAM_WR;
  logic [15:0]   CPU_DOUT, GFX_DOUT, RAM_DIN;
  logic [AB-1:0] RAM_ADDR;
  logic [15:0]   ram_dout;

  logic [15:0]   ram_mem [DEPTH];
  logic [15:0]   ref_mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  int          streak;
  int          exp_tag;
  logic [15:0] exp_data, cpu_hold_m, gfx_hold_m;

  always #5 CLK = ~CLK;

  mem_bank_arbiter #(.BITS(BITS), .ADDRESS_BITS(AB), .MAX_GFX_RUN(MAX_RUN)) dut (
    .CLK(CLK), .RSTb(rstb),
    .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din), .CPU_WR(cpu_wr), .CPU_RD(cpu_rd),
    .CPU_BUSY(CPU_BUSY), .CPU_VALID(CPU_VALID), .CPU_DOUT(CPU_DOUT),
    .GFX_ADDR(gfx_addr), .GFX_RD(gfx_rd),
    .GFX_BUSY(GFX_BUSY), .GFX_VALID(GFX_VALID), .GFX_DOUT(GFX_DOUT),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_WR(RAM_WR), .RAM_DOUT(ram_dout)
  );

  // Synchronous single-port RAM fixture.
  always @(posedge CLK) begin
    if (RAM_WR) ram_mem[RAM_ADDR] <= RAM_DIN;
    ram_dout <= ram_mem[RAM_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AB-1:0] a, input logic [15:0] d);
    ram_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AB-1:0] ca,
                       input logic [15:0] d, input logic grd, input logic [AB-1:0] ga);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = ca; cpu_din = d;
    gfx_rd = grd; gfx_addr = ga;
    #1;
  endtask

  task automatic model_reset();
    streak = 0; exp_tag = 0; exp_data = '0; cpu_hold_m = '0; gfx_hold_m = '0;
  endtask

  // One clock: check every output at the negedge, then advance the model at the posedge.
  task automatic cycle();
    bit creq, gg, cg;
    @(negedge CLK);
    creq = cpu_rd | cpu_wr;
    gg   = rstb && gfx_rd && (!creq || streak < MAX_RUN);
    cg   = rstb && creq && !gg;
    chk("cpu_busy",  32'(CPU_BUSY),  32'(creq && !cg));
    chk("gfx_busy",  32'(GFX_BUSY),  32'(gfx_rd && !gg));
    chk("ram_wr",    32'(RAM_WR),    32'(cg && cpu_wr));
    chk("ram_addr",  32'(RAM_ADDR),  32'(gg ? gfx_addr : cpu_addr));
    chk("ram_din",   32'(RAM_DIN),   32'(cpu_din));
    chk("cpu_valid", 32'(CPU_VALID), 32'(exp_tag == 1));
    chk("gfx_valid", 32'(GFX_VALID), 32'(exp_tag == 2));
    chk("cpu_dout",  32'(CPU_DOUT),  32'(exp_tag == 1 ? exp_data : cpu_hold_m));
    chk("gfx_dout",  32'(GFX_DOUT),  32'(exp_tag == 2 ? exp_data : gfx_hold_m));
    @(posedge CLK);
    if (!rstb) begin
      model_reset();
    end else begin
      if (exp_tag == 1) cpu_hold_m = exp_data;
      if (exp_tag == 2) gfx_hold_m = exp_data;
      if (gg && creq)         streak = (streak < MAX_RUN) ? streak + 1 : MAX_RUN;
      else if (cg || !creq)   streak = 0;
      if (gg) begin
        exp_tag = 2; exp_data = ref_mem[gfx_addr];
      end else if (cg && cpu_rd && !cpu_wr) begin
        exp_tag = 1; exp_data = ref_mem[cpu_addr];
      end else begin
        exp_tag = 0;
      end
      if (cg && cpu_wr) ref_mem[cpu_addr] = cpu_din;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) preload(AB'(i), 16'($urandom));
    preload(14'h0123, 16'hBEEF);
    rstb = 1'b0;
    drive(0, 0, '0, '0, 0, '0);
    @(posedge CLK); #1;
    model_reset();
    cycle();
    chk("rst_cpu_valid", 32'(CPU_VALID), 32'(0));
    chk("rst_cpu_dout",  32'(CPU_DOUT),  32'(0));
    rstb = 1'b1;

    // 1: lone CPU read, then hold
    drive(1, 0, 14'h0123, '0, 0, '0);
    chk("t1_busy", 32'(CPU_BUSY), 32'(0));
    cycle();
    drive(0, 0, '0, '0, 0, '0);
    chk("t1_valid", 32'(CPU_VALID), 32'(1));
    chk("t1_dout",  32'(CPU_DOUT),  32'h0000BEEF);
    cycle();
    chk("t1_hold",  32'(CPU_DOUT),  32'h0000BEEF);
    chk("t1_pulse", 32'(CPU_VALID), 32'(0));

    // 2: contention, gfx first
    drive(1, 0, 14'h0010, '0, 1, 14'h0020);
    chk("t2_cpu_busy", 32'(CPU_BUSY), 32'(1));
    chk("t2_gfx_busy", 32'(GFX_BUSY), 32'(0));
    cycle();
    drive(1, 0, 14'h0010, '0, 0, '0);
    chk("t2_cpu_grant", 32'(CPU_BUSY), 32'(0));
    chk("t2_gfx_valid", 32'(GFX_VALID), 32'(1));
    cycle();
    chk("t2_cpu_valid", 32'(CPU_VALID), 32'(1));

    // 3: bounded gfx run
    drive(1, 0, 14'h0011, '0, 1, 14'h0021);
    for (int i = 0; i < MAX_RUN; i++) begin
      chk("t3_gfx_run", 32'(CPU_BUSY), 32'(1));
      cycle();
    end
    chk("t3_cpu_turn", 32'(CPU_BUSY), 32'(0));
    chk("t3_gfx_wait", 32'(GFX_BUSY), 32'(1));
    cycle();
    chk("t3_gfx_resume", 32'(GFX_BUSY), 32'(0));
    chk("t3_cpu_valid",  32'(CPU_VALID), 32'(1));

    // 4: CPU write to the top address after a full gfx run
    drive(0, 1, 14'h3FFF, 16'h5A5A, 1, 14'h0030);
    for (int i = 0; i < MAX_RUN; i++) cycle();
    chk("t4_ram_wr",   32'(RAM_WR),   32'(1));
    chk("t4_ram_addr", 32'(RAM_ADDR), 32'h3FFF);
    cycle();
    drive(0, 0, '0, '0, 1, 14'h3FFF);
    cycle();
    drive(0, 0, '0, '0, 0, '0);
    chk("t4_gfx_dout", 32'(GFX_DOUT), 32'h5A5A);
    cycle();

    // 5: RD+WR together is a write only
    drive(1, 1, 14'h0001, 16'h1234, 0, '0);
    chk("t5_ram_wr", 32'(RAM_WR), 32'(1));
    cycle();
    drive(1, 0, 14'h0001, '0, 0, '0);
    chk("t5_no_valid", 32'(CPU_VALID), 32'(0));
    cycle();
    drive(0, 0, '0, '0, 0, '0);
    chk("t5_valid", 32'(CPU_VALID), 32'(1));
    chk("t5_dout",  32'(CPU_DOUT),  32'h1234);

    // 6: reset right after a gfx grant
    drive(0, 0, '0, '0, 1, 14'h0040);
    cycle();
    rstb = 1'b0;
    drive(0, 1, 14'h0050, 16'hDEAD, 1, 14'h0040);
    chk("t6_ram_wr",   32'(RAM_WR),   32'(0));
    chk("t6_cpu_busy", 32'(CPU_BUSY), 32'(1));
    cycle();
    chk("t6_gfx_valid", 32'(GFX_VALID), 32'(0));
    cycle();
    rstb = 1'b1;

    // Random traffic over a small address window plus the top address.
    for (int i = 0; i < 400; i++) begin
      logic [AB-1:0] ca, ga;
      ca = ($urandom_range(0, 7) == 0) ? 14'h3FFF : AB'($urandom_range(0, 15));
      ga = ($urandom_range(0, 7) == 0) ? 14'h3FFF : AB'($urandom_range(0, 15));
      rstb = ($urandom_range(0, 49) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), ca,
            16'($urandom), 1'($urandom_range(0, 3) != 0), ga);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
